instr_mem_sync: RTL and testbench
=================================

Name: instr_mem_sync

Overview:
Parametrised, registered instruction memory. It is the successor to the combinational byte-addressed instruction ROM and sits between the PC/fetch logic and the decode stage.
- Storage is byte-organised and assembled into INSTR_W-bit words with selectable endianness.
- Reads return one cycle after a request/ready handshake, and the output register holds its value under a downstream stall.
- A byte-wide load port writes program contents at runtime.
- Misaligned fetches are flagged and counted.

Parameters:
- INSTR_W, 16: instruction width in bits; must be a multiple of 8. BYTES = INSTR_W/8.
- ADDR_W, 8: byte-address width; depth = 2**ADDR_W bytes.
- BIG_ENDIAN, 1: 1 = byte at addr is the MSB of the word (current ISA ordering); 0 = byte at addr is the LSB.
- CHECK_ALIGN, 1: 1 = fetch with addr mod BYTES != 0 faults; 0 = unaligned fetch allowed.
- ERR_W, 8: width of the saturating fault counter.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- fetch_req, input, 1: fetch request.
- fetch_addr, input, ADDR_W: byte address of the instruction.
- fetch_ready, output, 1: block can accept a request this cycle.
- stall, input, 1: downstream cannot consume instr_out this cycle.
- instr_out, output, INSTR_W: fetched instruction.
- instr_valid, output, 1: instr_out/instr_fault are valid.
- instr_fault, output, 1: the fetch in the output register was misaligned.
- err_cnt, output, ERR_W: saturating count of faulted fetches.
- ld_en, input, 1: byte write enable.
- ld_addr, input, ADDR_W: byte write address.
- ld_data, input, 8: byte write data.

Behaviour:
- **Reset (reset=0):** asynchronous, takes effect without a clock edge.
  - instr_out=0, instr_valid=0, instr_fault=0, err_cnt=0.
  - fetch_ready=1 once reset is released.
  - Memory array is not cleared.
  - Any pending output is discarded; a request presented during reset is not accepted.
- **fetch_ready:** combinational, = !(instr_valid && stall).
- **Accept:** fetch_req && fetch_ready at a rising edge. Next cycle: instr_valid=1, and instr_out holds the word built from bytes fetch_addr+0 .. fetch_addr+BYTES-1.
- **Address wrap:** byte addresses are computed modulo 2**ADDR_W (wrap from top to 0).
- **Byte ordering:**
  - BIG_ENDIAN=1: byte at fetch_addr+0 goes to bits [INSTR_W-1 -: 8].
  - BIG_ENDIAN=0: byte at fetch_addr+0 goes to bits [7:0].
- **Latency:** 1 cycle. Throughput: 1 word/cycle when stall=0 (back-to-back accepts).
- **Hold:** while instr_valid && stall, instr_out, instr_valid and instr_fault hold unchanged, and no request is accepted.
- **Drain:** if instr_valid && !stall and no accept occurs, instr_valid=0 next cycle; instr_out keeps its last value (don't-care).
- **Misaligned fetch** (CHECK_ALIGN=1 and fetch_addr mod BYTES != 0), on accept:
  - instr_valid=1, instr_fault=1, instr_out=0.
  - err_cnt increments by 1 and saturates at all-ones.
  - An aligned fetch sets instr_fault=0.
  - With CHECK_ALIGN=0 no fault is ever raised.
- **Load port:** ld_en at a rising edge writes ld_data to mem[ld_addr]. There is no handshake; the load port is always accepted, even during a stall.
- **Same-edge load and fetch** touching the same byte: the fetch returns the old byte (read-before-write). The new byte is visible to fetches accepted on later edges.
- **Simultaneous accept and counter saturation:** err_cnt stays at max with no wrap.
- **Control inputs during reset:** ld_en, fetch_req and stall are ignored while reset=0.

Test Plan:
1. INSTR_W=16, BIG_ENDIAN=1: load 0x31@0, 0x12@1; fetch addr 0 with stall=0 -> next cycle instr_valid=1, instr_out=0x3112, instr_fault=0; the cycle after, instr_valid=0.
2. BIG_ENDIAN=0, same bytes and fetch -> instr_out=0x1231. Then back-to-back fetches of 0, 2, 4 on consecutive cycles -> three consecutive valid words, fetch_ready constantly 1.
3. CHECK_ALIGN=0: load 0xAB@255, 0xCD@0; fetch 255 -> instr_out=0xABCD (wrap), instr_fault=0.
4. CHECK_ALIGN=1: fetch addr 1 -> instr_valid=1, instr_fault=1, instr_out=0, err_cnt=1. Then 300 misaligned fetches with ERR_W=8 -> err_cnt=255, held at 255.
5. Stall: after fetch 0 returns 0x3112, hold stall=1 for 3 cycles with fetch_req=1, fetch_addr=2 -> fetch_ready=0 and instr_out=0x3112 stable for those 3 cycles. Drop stall -> request accepted on that edge, next cycle shows word@2.
6. Drive ld_en (0x55@0) and a fetch of 0 on the same edge -> instr_out=0x3112 (old data); fetch 0 again -> 0x5512. Then pull reset low mid-cycle while instr_valid=1 -> instr_valid, instr_fault, instr_out and err_cnt go to 0 with no clock edge; after release, fetch 0 still returns 0x5512 (memory retained).

Source files
------------

// File: rtl/instr_mem_sync.sv
// ----------------------------------------------------------------------------
// instr_mem_sync
//
// Registered, byte-organised instruction memory sitting between the fetch
// logic and decode. A fetch request is accepted on a request/ready handshake
// and the assembled instruction word appears in the output register one cycle
// later. The output register holds its contents while the consumer stalls.
// A byte-wide load port writes program contents at runtime, and misaligned
// fetches are flagged and counted.
//
// Parameters
//   INSTR_W     instruction width in bits (multiple of 8)
//   ADDR_W      byte-address width, depth = 2**ADDR_W bytes
//   BIG_ENDIAN  1: byte at the fetch address is the word MSB, 0: it is the LSB
//   CHECK_ALIGN 1: fetch address not a multiple of INSTR_W/8 faults
//   ERR_W       width of the saturating fault counter
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   fetch_req    fetch request
//   fetch_addr   byte address of the instruction
//   fetch_ready  request can be accepted this cycle
//   stall        downstream cannot consume instr_out this cycle
//   instr_out    fetched instruction word
//   instr_valid  instr_out / instr_fault are valid
//   instr_fault  the fetch held in the output register was misaligned
//   err_cnt      saturating count of faulted fetches
//   ld_en        byte write enable
//   ld_addr      byte write address
//   ld_data      byte write data
// ----------------------------------------------------------------------------
module instr_mem_sync #(
    parameter int INSTR_W     = 16,
    parameter int ADDR_W      = 8,
    parameter int BIG_ENDIAN  = 1,
    parameter int CHECK_ALIGN = 1,
    parameter int ERR_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_ready,
    input  logic               stall,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic               instr_fault,
    output logic [ERR_W-1:0]   err_cnt,
    input  logic               ld_en,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [7:0]         ld_data
);

    localparam int BYTES = INSTR_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    // Fault counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + ERR_W'(1);
    endfunction

    // A fetch faults only when alignment checking is on and the byte address
    // is not on an instruction boundary.
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        if (CHECK_ALIGN == 0) begin
            return 1'b0;
        end
        return (int'(addr) % BYTES) != 0;
    endfunction

    logic [7:0]         mem [DEPTH];
    logic               ld_we;
    logic               accept;

    logic [INSTR_W-1:0] word_p0;
    logic               misal_p0;

    logic [INSTR_W-1:0] instr_p1;
    logic               vld_p1;
    logic               fault_p1;
    logic [ERR_W-1:0]   err_p1;

    // Loads are dropped while reset is asserted; the array itself is never
    // cleared so program contents survive a reset.
    assign ld_we = ld_en && reset;

    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // ---- stage p0: address decode and word assembly (combinational) ----
    // Byte addresses wrap naturally because the sum stays ADDR_W bits wide.
    // Reading the array here while the load port writes it with a
    // non-blocking assignment gives read-before-write on a shared edge.
    always_comb begin
        word_p0 = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (BIG_ENDIAN != 0) begin
                word_p0[INSTR_W-1-8*i -: 8] = mem[fetch_addr + ADDR_W'(i)];
            end else begin
                word_p0[8*i +: 8] = mem[fetch_addr + ADDR_W'(i)];
            end
        end
    end

    assign misal_p0    = is_misaligned(fetch_addr);
    assign fetch_ready = !(vld_p1 && stall);
    assign accept      = fetch_req && fetch_ready;

    // ---- stage p1: output register ----
    // A valid word under stall freezes the whole register. Without an accept
    // and without a stall the word has been consumed, so valid drops; the
    // data bits are left as they are.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_p1 <= '0;
            vld_p1   <= 1'b0;
            fault_p1 <= 1'b0;
            err_p1   <= '0;
        end else begin
            if (accept) begin
                vld_p1   <= 1'b1;
                fault_p1 <= misal_p0;
                instr_p1 <= misal_p0 ? '0 : word_p0;
                if (misal_p0) begin
                    err_p1 <= sat_inc(err_p1);
                end
            end else if (fetch_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign instr_out   = instr_p1;
    assign instr_valid = vld_p1;
    assign instr_fault = fault_p1;
    assign err_cnt     = err_p1;

endmodule

// File: tb/tb_instr_mem_sync.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_sync
//
// Three instances share one stimulus stream:
//   u0: big-endian, alignment checked
//   u1: little-endian, unaligned allowed
//   u2: big-endian, unaligned allowed
// A byte-array reference model predicts every instance's outputs.
// ----------------------------------------------------------------------------
module tb_instr_mem_sync;

    localparam int NI = 3;
    localparam logic [NI-1:0] BE_P = 3'b101;
    localparam logic [NI-1:0] CA_P = 3'b001;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic        stall;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [7:0]  ld_data;

    logic        rdy  [NI];
    logic [15:0] dout [NI];
    logic        vld  [NI];
    logic        flt  [NI];
    logic [7:0]  err  [NI];

    int total;
    int bad;

    // reference model state
    logic [7:0]  m_mem [256];
    bit          m_valid;
    logic [15:0] m_out   [NI];
    bit          m_fault [NI];
    int          m_err   [NI];

    instr_mem_sync #(.INSTR_W(16), .ADDR_W(8), .BIG_ENDIAN(1), .CHECK_ALIGN(1), .ERR_W(8)) u0 (
        .clk(clk), .reset(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(rdy[0]), .stall(stall), .instr_out(dout[0]), .instr_valid(vld[0]),
        .instr_fault(flt[0]), .err_cnt(err[0]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    instr_mem_sync #(.INSTR_W(16), .ADDR_W(8), .BIG_ENDIAN(0), .CHECK_ALIGN(0), .ERR_W(8)) u1 (
        .clk(clk), .reset(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(rdy[1]), .stall(stall), .instr_out(dout[1]), .instr_valid(vld[1]),
        .instr_fault(flt[1]), .err_cnt(err[1]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    instr_mem_sync #(.INSTR_W(16), .ADDR_W(8), .BIG_ENDIAN(1), .CHECK_ALIGN(0), .ERR_W(8)) u2 (
        .clk(clk), .reset(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(rdy[2]), .stall(stall), .instr_out(dout[2]), .instr_valid(vld[2]),
        .instr_fault(flt[2]), .err_cnt(err[2]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word made of the bytes at a and a+1 (wrapping at 256), in the requested order.
    function automatic logic [15:0] mword(input logic [7:0] a, input bit be);
        logic [7:0] b0;
        logic [7:0] b1;
        b0 = m_mem[int'(a)];
        b1 = m_mem[(int'(a) + 1) % 256];
        return be ? {b0, b1} : {b1, b0};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        for (int k = 0; k < NI; k++) begin
            m_out[k]   = '0;
            m_fault[k] = 1'b0;
            m_err[k]   = 0;
        end
    endtask

    task automatic check_outs();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("valid%0d", k), vld[k], m_valid);
            if (m_valid) begin
                chk($sformatf("out%0d", k), dout[k], m_out[k]);
                chk($sformatf("fault%0d", k), flt[k], m_fault[k]);
            end
            chk($sformatf("errcnt%0d", k), err[k], m_err[k]);
        end
    endtask

    // One clock: called just after a falling edge; drives inputs, checks the
    // combinational ready, advances the model across the rising edge, and
    // checks the registered outputs at the next falling edge.
    task automatic cyc(input bit req, input logic [7:0] a, input bit st,
                       input bit le, input logic [7:0] la, input logic [7:0] ld);
        bit rdy_e;
        bit mis;
        fetch_req  = req;
        fetch_addr = a;
        stall      = st;
        ld_en      = le;
        ld_addr    = la;
        ld_data    = ld;
        #1;
        rdy_e = !(m_valid && st);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("ready%0d", k), rdy[k], rdy_e);
        end
        if (rst_n) begin
            if (req && rdy_e) begin
                for (int k = 0; k < NI; k++) begin
                    mis        = CA_P[k] && ((int'(a) % 2) != 0);
                    m_out[k]   = mis ? 16'h0000 : mword(a, BE_P[k]);
                    m_fault[k] = mis;
                    if (mis && m_err[k] < 255) begin
                        m_err[k] = m_err[k] + 1;
                    end
                end
                m_valid = 1'b1;
            end else if (rdy_e) begin
                m_valid = 1'b0;
            end
            if (le) begin
                m_mem[int'(la)] = ld;
            end
        end
        @(negedge clk);
        check_outs();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        stall      = 1'b0;
        ld_en      = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;
        rst_n      = 1'b1;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        model_reset();

        // reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outs();
        rst_n = 1'b1;

        // fill program memory with random bytes
        for (int i = 0; i < 256; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'(i), 8'($urandom));
        end

        // basic fetch, both byte orders, then drain
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h31);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h12);
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("t1_be_word", dout[0], 16'h3112);
        chk("t1_le_word", dout[1], 16'h1231);
        chk("t1_fault", flt[0], 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("t1_drain", vld[0], 1'b0);

        // back-to-back fetches
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

        // address wrap at the top of memory
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 8'hAB);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'hCD);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("t3_wrap_be", dout[2], 16'hABCD);
        chk("t3_wrap_le", dout[1], 16'hCDAB);
        chk("t3_nofault", flt[2], 1'b0);
        chk("t3_fault_chk", flt[0], 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h31);

        // misaligned fetch and counter saturation
        cyc(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("t4_fault", flt[0], 1'b1);
        chk("t4_zero", dout[0], 16'h0000);
        chk("t4_cnt", err[0], 8'd2);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 8'($urandom) | 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        chk("t4_sat", err[0], 8'd255);
        cyc(1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("t4_sat_hold", err[0], 8'd255);

        // stall holds the output and blocks requests
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("t5_word", dout[0], 16'h3112);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h02, 1'b1, 1'b0, 8'h00, 8'h00);
            chk("t5_ready_low", rdy[0], 1'b0);
            chk("t5_hold", dout[0], 16'h3112);
        end
        cyc(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 8'h00);

        // same-edge load and fetch: old byte first, new byte after
        cyc(1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 8'h55);
        chk("t6_old", dout[0], 16'h3112);
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("t6_new", dout[0], 16'h5512);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            cyc(1'($urandom), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                1'($urandom), 8'($urandom), 8'($urandom));
        end

        // asynchronous reset mid-cycle with a valid word in the register
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h55);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h12);
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("t7_pre_valid", vld[0], 1'b1);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("t7_out_zero%0d", k), dout[k], 16'h0000);
            chk($sformatf("t7_fault_zero%0d", k), flt[k], 1'b0);
        end
        @(negedge clk);
        // loads, requests and stall are ignored during reset
        cyc(1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 8'h99);
        rst_n = 1'b1;
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("t7_retained", dout[0], 16'h5512);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
